// File: rtl/inst_type_stage_pkg.sv
// Shared instruction-set constants for the instruction classification stage.
// Holds the 4-bit opcodes, the 6-bit R-type function codes and the 3-bit
// INSTTYPE class codes used by the classifier, the FIFO and the event
// counters. Instruction fields: opcode = inst[15:12], func = inst[5:0].
package inst_type_stage_pkg;

  // Opcodes (inst[15:12])
  localparam logic [3:0] OPCODE_BNE   = 4'd0;
  localparam logic [3:0] OPCODE_BEQ   = 4'd1;
  localparam logic [3:0] OPCODE_BGZ   = 4'd2;
  localparam logic [3:0] OPCODE_BLZ   = 4'd3;
  localparam logic [3:0] OPCODE_ADI   = 4'd4;
  localparam logic [3:0] OPCODE_ORI   = 4'd5;
  localparam logic [3:0] OPCODE_LHI   = 4'd6;
  localparam logic [3:0] OPCODE_LWD   = 4'd7;
  localparam logic [3:0] OPCODE_SWD   = 4'd8;
  localparam logic [3:0] OPCODE_JMP   = 4'd9;
  localparam logic [3:0] OPCODE_JAL   = 4'd10;
  localparam logic [3:0] OPCODE_RTYPE = 4'd15;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;
  // All-ones function field is reserved as an explicit no-op
  localparam logic [5:0] FUNC_NOP = 6'b111111;

  // Instruction classes; the numeric value doubles as the counter index
  typedef enum logic [2:0] {
    INSTTYPE_RTYPE  = 3'd0,
    INSTTYPE_LOAD   = 3'd1,
    INSTTYPE_STORE  = 3'd2,
    INSTTYPE_BRANCH = 3'd3,
    INSTTYPE_JUMP   = 3'd4,
    INSTTYPE_OUTPUT = 3'd5,
    INSTTYPE_NOP    = 3'd6
  } insttype_e;

  localparam int INSTTYPE_COUNT = 7;

endpackage

// File: rtl/inst_type_lane.sv
// Combinational classifier for one instruction lane.
// Ports:
//   opcode_i  - inst[15:12] of the lane
//   func_i    - inst[5:0] of the lane
//   en_i      - lane enable; a disabled lane always reports NOP
//   type_o    - INSTTYPE class code of the lane
module inst_type_lane
  import inst_type_stage_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [5:0] func_i,
  input  logic       en_i,
  output logic [2:0] type_o
);

  insttype_e laneType;

  // Opcode decides the class directly except for the R-type/immediate ALU
  // group, where the function field picks out jumps, output and no-ops.
  always_comb begin
    laneType = INSTTYPE_NOP;
    case (opcode_i)
      OPCODE_RTYPE, OPCODE_ADI, OPCODE_ORI: begin
        case (func_i)
          FUNC_JPR, FUNC_JRL: laneType = INSTTYPE_JUMP;
          FUNC_WWD:           laneType = INSTTYPE_OUTPUT;
          FUNC_NOP:           laneType = INSTTYPE_NOP;
          default:            laneType = INSTTYPE_RTYPE;
        endcase
      end
      OPCODE_LHI, OPCODE_LWD:                         laneType = INSTTYPE_LOAD;
      OPCODE_SWD:                                     laneType = INSTTYPE_STORE;
      OPCODE_BNE, OPCODE_BEQ, OPCODE_BGZ, OPCODE_BLZ: laneType = INSTTYPE_BRANCH;
      OPCODE_JMP, OPCODE_JAL:                         laneType = INSTTYPE_JUMP;
      default:                                        laneType = INSTTYPE_NOP;
    endcase
  end

  assign type_o = en_i ? laneType : INSTTYPE_NOP;

endmodule

// File: rtl/inst_type_stage.sv
// Instruction classification pipeline stage.
// Classifies LANES 16-bit instructions per beat, buffers beats in a 2-entry
// FIFO with valid/ready handshakes on both sides, and keeps one saturating
// event counter per instruction class that advances on each output handshake.
// Ports:
//   clk, reset_n              - clock, synchronous active-low reset
//   in_valid/in_ready         - upstream handshake
//   in_inst, in_lane_en       - beat payload (lane k at in_inst[16k+15:16k])
//   out_valid/out_ready       - downstream handshake
//   out_inst, out_type        - FIFO head payload and per-lane class codes
//   out_lane_en               - FIFO head lane enables
//   flush                     - drop all buffered beats
//   cnt_clr                   - zero all class counters
//   cnt_sel, cnt_value        - counter select and its registered read value
module inst_type_stage
  import inst_type_stage_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*16-1:0]  in_inst,
  input  logic [LANES-1:0]     in_lane_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*16-1:0]  out_inst,
  output logic [LANES*3-1:0]   out_type,
  output logic [LANES-1:0]     out_lane_en,
  input  logic                 flush,
  input  logic                 cnt_clr,
  input  logic [2:0]           cnt_sel,
  output logic [CNT_W-1:0]     cnt_value
);

  typedef struct packed {
    logic [LANES*16-1:0] inst;
    logic [LANES-1:0]    laneEn;
    logic [LANES*3-1:0]  laneType;
  } entry_t;

  logic [LANES*3-1:0] pushType;
  entry_t             entry_q [2];
  entry_t             headEntry;
  logic               wrPtr_q, wrPtr_d;
  logic               rdPtr_q, rdPtr_d;
  logic [1:0]         occ_q, occ_d;
  logic               push, pop, countPop;

  logic [2:0]         incCount [INSTTYPE_COUNT];
  logic [CNT_W-1:0]   cnt_q    [INSTTYPE_COUNT];
  logic [CNT_W-1:0]   cnt_d    [INSTTYPE_COUNT];
  logic [CNT_W-1:0]   cntValue_q, cntValue_d;

  // Classification happens on the way in so the stored type travels with
  // its instruction and the output side is a plain register read.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    inst_type_lane u_lane (
      .opcode_i (in_inst[16*k+12 +: 4]),
      .func_i   (in_inst[16*k +: 6]),
      .en_i     (in_lane_en[k]),
      .type_o   (pushType[3*k +: 3])
    );
  end

  // Full FIFO refuses a push even if it is popping this cycle, and flush
  // blocks pushes so nothing slips in behind the discard.
  assign in_ready  = (occ_q != 2'd2) & ~flush;
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign countPop  = pop & ~flush;

  assign headEntry   = entry_q[rdPtr_q];
  assign out_inst    = out_valid ? headEntry.inst     : '0;
  assign out_type    = out_valid ? headEntry.laneType : '0;
  assign out_lane_en = out_valid ? headEntry.laneEn   : '0;

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_comb begin
    occ_d   = occ_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush) begin
      occ_d   = 2'd0;
      wrPtr_d = 1'b0;
      rdPtr_d = 1'b0;
    end else begin
      if (push) wrPtr_d = ~wrPtr_q;
      if (pop)  rdPtr_d = ~rdPtr_q;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_q   <= 2'd0;
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // FIFO storage; push already implies no flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
    end else if (push) begin
      entry_q[wrPtr_q] <= {in_inst, in_lane_en, pushType};
    end
  end

  // Per-class count of enabled lanes in the head beat. The enable is
  // checked explicitly because disabled lanes are stored as NOP and must
  // not be counted as NOPs.
  always_comb begin
    for (int t = 0; t < INSTTYPE_COUNT; t++) begin
      incCount[t] = 3'd0;
      for (int k = 0; k < LANES; k++) begin
        if (headEntry.laneEn[k] && (headEntry.laneType[3*k +: 3] == 3'(t)))
          incCount[t] = incCount[t] + 3'd1;
      end
    end
  end

  // Add with clamp at all-ones; the three guard bits cover the largest
  // per-beat increment even for very narrow counters.
  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                              input logic [2:0] b);
    logic [CNT_W+2:0] sum;
    sum = {3'b000, a} + {{CNT_W{1'b0}}, b};
    if (sum[CNT_W+2:CNT_W] != 3'b000) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // Clear beats any increment; a pop during flush is not counted.
  always_comb begin
    for (int t = 0; t < INSTTYPE_COUNT; t++) begin
      cnt_d[t] = cnt_q[t];
      if (cnt_clr)       cnt_d[t] = '0;
      else if (countPop) cnt_d[t] = satAdd(cnt_q[t], incCount[t]);
    end
  end

  // Read port; the one code outside the class range reads zero.
  always_comb begin
    cntValue_d = '0;
    if (cnt_sel < 3'(INSTTYPE_COUNT)) cntValue_d = cnt_q[cnt_sel];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int t = 0; t < INSTTYPE_COUNT; t++) cnt_q[t] <= '0;
      cntValue_q <= '0;
    end else begin
      for (int t = 0; t < INSTTYPE_COUNT; t++) cnt_q[t] <= cnt_d[t];
      cntValue_q <= cntValue_d;
    end
  end

  assign cnt_value = cntValue_q;

endmodule

// File: doc/inst_type_stage.md
INST_TYPE_STAGE -- requirements
Module: inst_type_stage

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning instructions classified per beat (legal range 1..4).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each per-type event counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-006 SHALL have port in_ready, output, 1, stage accepts a beat this cycle.
REQ-007 SHALL have port in_inst, input, LANES*16, 16-bit instructions; lane k at bits [16k+15:16k].
REQ-008 SHALL have port in_lane_en, input, LANES, per-lane enable within the beat.
REQ-009 SHALL have port out_valid, output, 1, classified beat available.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts beat.
REQ-011 SHALL have port out_inst, output, LANES*16, instructions passed through unchanged.
REQ-012 SHALL have port out_type, output, LANES*3, INSTTYPE code per lane.
REQ-013 SHALL have port out_lane_en, output, LANES, lane enables passed through.
REQ-014 SHALL have port flush, input, 1, discard all buffered beats.
REQ-015 SHALL have port cnt_clr, input, 1, clear all counters.
REQ-016 SHALL have port cnt_sel, input, 3, INSTTYPE code selecting a counter to read.
REQ-017 SHALL have port cnt_value, output, CNT_W, registered value of the selected counter.

Function
REQ-018 SHALL decode per lane: opcode = inst[15:12], func = inst[5:0].
REQ-019 SHALL map OPCODE_RTYPE/ADI/ORI to JUMP for FUNC_JPR/FUNC_JRL, OUTPUT for FUNC_WWD, NOP for func 6'b111111, RTYPE otherwise.
REQ-020 SHALL map LHI/LWD to LOAD, SWD to STORE, BNE/BEQ/BGZ/BLZ to BRANCH, JMP/JAL to JUMP, every other opcode to NOP.
REQ-021 SHALL force out_type of a lane to INSTTYPE_NOP when its lane enable is 0.
REQ-022 SHALL classify at push time and store inst, enable and type together in a 2-entry FIFO.
REQ-023 SHALL accept a beat when in_valid & in_ready; in_ready = (occupancy < 2) & ~flush.
REQ-024 SHALL drive out_valid = (occupancy > 0), with outputs taken from the FIFO head; a beat accepted at edge N appears at out_valid in the cycle after edge N (latency 1).
REQ-025 SHALL hold out_* stable while out_valid & ~out_ready.
REQ-026 SHALL keep occupancy unchanged on simultaneous push and pop at occupancy 1; no push at occupancy 2.
REQ-027 SHALL on flush set occupancy to 0 at the next edge; flush overrides a simultaneous push and pop; a pop in the flush cycle SHALL NOT update counters.
REQ-028 SHALL keep 7 counters, one per INSTTYPE (RTYPE, LOAD, STORE, BRANCH, JUMP, OUTPUT, NOP); on each out handshake, add to each counter the number of enabled lanes of that type (disabled lanes count nowhere).
REQ-029 SHALL saturate counters at all-ones, never wrap.
REQ-030 SHALL on cnt_clr zero all counters at the next edge; cnt_clr wins over same-cycle increments.
REQ-031 SHALL register cnt_value one cycle after cnt_sel; unused cnt_sel codes read 0.

Reset
REQ-032 SHALL on reset_n=0 at an edge set occupancy 0, all counters 0, cnt_value 0; in_ready=1, out_valid=0 following; out_inst/out_type/out_lane_en read 0 while empty.
REQ-033 SHALL discard any in-flight beat on reset mid-operation; no counter increment in the reset cycle.

Structure
REQ-034 SHALL take OPCODE_*, FUNC_*, INSTTYPE_* from the shared constants.v; add INSTTYPE_COUNT=7 there.
REQ-035 SHALL implement per-lane decode in a combinational sub-module inst_type_lane, instantiated LANES times.

Verification
REQ-036 SHALL check LANES=2, beat {16'hF01C (WWD), 16'h7000 (LWD)}, en=2'b11 -> next cycle out_type {OUTPUT, LOAD}, OUTPUT and LOAD counters = 1 after handshake.
REQ-037 SHALL check out_ready=0 for 3 cycles with 3 offered beats -> exactly 2 accepted, in_ready=0, head stable; release -> beats in order.
REQ-038 SHALL check en=2'b01 with lane1 = BEQ 16'h1000 -> lane1 type NOP, BRANCH counter unchanged.
REQ-039 SHALL check flush with occupancy 2 and in_valid=1 -> occupancy 0 next cycle, beat not accepted, counters unchanged.
REQ-040 SHALL check CNT_W=4, 20 RTYPE lanes -> RTYPE counter 15; cnt_clr with concurrent handshake -> 0.
REQ-041 SHALL check reset_n=0 mid-stream -> out_valid=0, all counters 0, in_ready=1 after release.
